// File: rtl/nav_pkg.sv
// Shared navigation definitions: node ID type, sequencer state codes and
// turn-direction codes common to the path sequencer and the direction decoder.
package nav_pkg;

   localparam int NODE_W = 5;

   typedef logic [NODE_W-1:0] node_t;

   // Sequencer states, kept as plain constants so older tools can consume them
   typedef logic [1:0] seq_state_t;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_RETURN = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   // Turn-direction codes produced by the decoder from a node triple
   typedef enum logic [1:0] {
      DIR_STRAIGHT = 2'd0,
      DIR_LEFT     = 2'd1,
      DIR_RIGHT    = 2'd2,
      DIR_REVERSE  = 2'd3
   } dir_e;

   // A route needs at least two nodes and must fit in the path memory
   function automatic logic route_len_legal(input int len, input int depth);
      return (len >= 2) && (len <= depth);
   endfunction

endpackage

// File: rtl/path_sequencer.sv
// Path sequencer: stores a planned route and presents the prev/curr/next node
// triple to the turn-direction decoder, advancing on every node-detected event.
// Optional feature macro: PATH_RETURN_EN -- after the last node the route is
// traversed in reverse back to node 0 before finishing.
module path_sequencer #(
   parameter  int DEPTH  = 32,
   parameter  int NODE_W = nav_pkg::NODE_W,
   localparam int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_addr,
   input  logic [NODE_W-1:0] wr_data,
   input  logic [IDX_W:0]    path_len,
   input  logic              start,
   input  logic              abort,
   input  logic              node_evt,
   output logic [NODE_W-1:0] prev_node,
   output logic [NODE_W-1:0] curr_node,
   output logic [NODE_W-1:0] next_node,
   output logic              nodes_valid,
   output logic              busy,
   output logic              done,
   output logic              err
);
   import nav_pkg::*;

   logic [NODE_W-1:0] mem_q [DEPTH];

   seq_state_t        state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W:0]    len_q, len_d;
   logic [NODE_W-1:0] prev_q, prev_d;
   logic [NODE_W-1:0] curr_q, curr_d;
   logic [NODE_W-1:0] next_q, next_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic              wr_ok;
   logic              start_legal;
   logic [IDX_W-1:0]  ptr_inc;
   logic              at_last;
   logic [IDX_W-1:0]  idx_fwd;

   assign start_legal = route_len_legal(int'(path_len), DEPTH);
   assign ptr_inc     = ptr_q + IDX_W'(1);
   // The node about to become current is the final one of the route
   assign at_last     = ({1'b0, ptr_inc} == (len_q - (IDX_W+1)'(1)));
   assign idx_fwd     = ptr_q + IDX_W'(2);

`ifdef PATH_RETURN_EN
   logic [IDX_W-1:0] idx_turn;
   logic [IDX_W-1:0] idx_back;
   // Turnaround looks one node behind the last; reverse walk looks two back
   assign idx_turn = IDX_W'(len_q - (IDX_W+1)'(2));
   assign idx_back = ptr_q - IDX_W'(2);
`endif

   // Next-state logic: route launch, per-event advance, abort and finish
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      len_d   = len_q;
      prev_d  = prev_q;
      curr_d  = curr_q;
      next_d  = next_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      wr_ok   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Loading is only allowed while idle; a write racing an accepted
            // start is dropped so the route cannot change under the launch
            wr_ok = wr_en && !(start && start_legal);
            if (start) begin
               if (start_legal) begin
                  len_d   = path_len;
                  ptr_d   = '0;
                  prev_d  = mem_q[0];
                  curr_d  = mem_q[0];
                  next_d  = mem_q[1];
                  valid_d = 1'b1;
                  state_d = ST_RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (node_evt) begin
               ptr_d   = ptr_inc;
               prev_d  = curr_q;
               curr_d  = next_q;
               valid_d = 1'b1;
               if (at_last) begin
`ifdef PATH_RETURN_EN
                  next_d  = mem_q[idx_turn];
                  state_d = ST_RETURN;
`else
                  // Repeating the current node tells the decoder to stop
                  next_d  = next_q;
                  state_d = ST_DONE;
`endif
               end else begin
                  next_d = mem_q[idx_fwd];
               end
            end
         end
`ifdef PATH_RETURN_EN
         ST_RETURN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (node_evt) begin
               ptr_d   = ptr_q - IDX_W'(1);
               prev_d  = curr_q;
               curr_d  = next_q;
               valid_d = 1'b1;
               if (ptr_q == IDX_W'(1)) begin
                  next_d  = next_q;
                  state_d = ST_DONE;
               end else begin
                  next_d = mem_q[idx_back];
               end
            end
         end
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and node-triple registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         len_q   <= '0;
         prev_q  <= '0;
         curr_q  <= '0;
         next_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         len_q   <= len_d;
         prev_q  <= prev_d;
         curr_q  <= curr_d;
         next_q  <= next_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   // Path memory: survives reset, written by the planner while idle
   always_ff @(posedge clk) begin
      if (wr_ok && !rst) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign prev_node   = prev_q;
   assign curr_node   = curr_q;
   assign next_node   = next_q;
   assign nodes_valid = valid_q;
   assign err         = err_q;
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_path_sequencer.sv
// Directed testbench for path_sequencer with hand-computed node triples.
module tb_path_sequencer;

   localparam int DEPTH  = 32;
   localparam int NODE_W = 5;
   localparam int IDX_W  = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              wr_en = 1'b0;
   logic [IDX_W-1:0]  wr_addr = '0;
   logic [NODE_W-1:0] wr_data = '0;
   logic [IDX_W:0]    path_len = '0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              node_evt = 1'b0;
   logic [NODE_W-1:0] prev_node, curr_node, next_node;
   logic              nodes_valid, busy, done, err;

   int n_tests = 0;
   int n_fail  = 0;

   path_sequencer #(.DEPTH(DEPTH), .NODE_W(NODE_W)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .path_len(path_len), .start(start), .abort(abort), .node_evt(node_evt),
      .prev_node(prev_node), .curr_node(curr_node), .next_node(next_node),
      .nodes_valid(nodes_valid), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] trip(input int a, input int b, input int c);
      return 32'({a[4:0], b[4:0], c[4:0]});
   endfunction

   function automatic logic [31:0] obs();
      return 32'({prev_node, curr_node, next_node});
   endfunction

   task automatic wr(input int addr, input int data);
      wr_en   = 1'b1;
      wr_addr = IDX_W'(addr);
      wr_data = NODE_W'(data);
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic go(input int len);
      start    = 1'b1;
      path_len = (IDX_W+1)'(len);
      tick();
      start    = 1'b0;
   endtask

   task automatic evt();
      node_evt = 1'b1;
      tick();
      node_evt = 1'b0;
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_triple", obs(), 32'd0);
      chk("rst_valid", 32'(nodes_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst = 1'b0;

`ifndef PATH_RETURN_EN
      // Load route [0,1,2,29] and walk it
      wr(0, 0); wr(1, 1); wr(2, 2); wr(3, 29);
      go(4);
      chk("start_triple", obs(), trip(0, 0, 1));
      chk("start_valid", 32'(nodes_valid), 32'd1);
      chk("start_busy", 32'(busy), 32'd1);
      evt();
      chk("ev1_triple", obs(), trip(0, 1, 2));
      chk("ev1_valid", 32'(nodes_valid), 32'd1);
      evt();
      chk("ev2_triple", obs(), trip(1, 2, 29));
      chk("ev2_done", 32'(done), 32'd0);
      evt();
      chk("ev3_triple", obs(), trip(2, 29, 29));
      chk("ev3_done", 32'(done), 32'd1);
      chk("ev3_busy", 32'(busy), 32'd1);
      tick();
      chk("post_done", 32'(done), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_valid", 32'(nodes_valid), 32'd0);
      chk("post_hold", obs(), trip(2, 29, 29));

      // Illegal lengths
      go(1);
      chk("len1_err", 32'(err), 32'd1);
      chk("len1_busy", 32'(busy), 32'd0);
      chk("len1_hold", obs(), trip(2, 29, 29));
      chk("len1_valid", 32'(nodes_valid), 32'd0);
      tick();
      chk("err_pulse", 32'(err), 32'd0);
      go(33);
      chk("len33_err", 32'(err), 32'd1);
      chk("len33_busy", 32'(busy), 32'd0);
      tick();

      // Abort beats the first node event
      go(4);
      node_evt = 1'b1;
      abort    = 1'b1;
      tick();
      node_evt = 1'b0;
      abort    = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_hold", obs(), trip(0, 0, 1));
      chk("abort_valid", 32'(nodes_valid), 32'd0);
      tick();
      chk("abort_nodone", 32'(done), 32'd0);

      // Abort coincident with the second node event
      go(4);
      evt();
      node_evt = 1'b1;
      abort    = 1'b1;
      tick();
      node_evt = 1'b0;
      abort    = 1'b0;
      chk("abort2_hold", obs(), trip(0, 1, 2));
      chk("abort2_busy", 32'(busy), 32'd0);
      chk("abort2_done", 32'(done), 32'd0);

      // Write with accepted start and during RUN are both dropped
      wr_en   = 1'b1;
      wr_addr = 5'd3;
      wr_data = 5'd9;
      go(4);
      wr_en   = 1'b0;
      wr(2, 7);
      chk("wrrun_busy", 32'(busy), 32'd1);
      evt();
      chk("wrrun_ev1", obs(), trip(0, 1, 2));
      evt();
      chk("wrrun_ev2", obs(), trip(1, 2, 29));
      evt();
      chk("wrrun_ev3", obs(), trip(2, 29, 29));
      chk("wrrun_done", 32'(done), 32'd1);
      tick();

      // Reset mid-run overrides a coincident event
      go(4);
      evt();
      rst      = 1'b1;
      node_evt = 1'b1;
      tick();
      rst      = 1'b0;
      node_evt = 1'b0;
      chk("midrst_triple", obs(), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_valid", 32'(nodes_valid), 32'd0);
      go(4);
      chk("replay_start", obs(), trip(0, 0, 1));
      evt();
      chk("replay_ev1", obs(), trip(0, 1, 2));
      abort = 1'b1;
      tick();
      abort = 1'b0;

      // Shortest legal route finishes on its first event
      go(2);
      chk("len2_start", obs(), trip(0, 0, 1));
      evt();
      chk("len2_ev1", obs(), trip(0, 1, 1));
      chk("len2_done", 32'(done), 32'd1);
      tick();

      // Longest legal route is accepted
      go(32);
      chk("len32_err", 32'(err), 32'd0);
      chk("len32_busy", 32'(busy), 32'd1);
      chk("len32_triple", obs(), trip(0, 0, 1));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("len32_abort", 32'(busy), 32'd0);
`else
      // Out-and-back traversal of route [3,4,5]
      wr(0, 3); wr(1, 4); wr(2, 5);
      go(3);
      chk("ret_start", obs(), trip(3, 3, 4));
      evt();
      chk("ret_ev1", obs(), trip(3, 4, 5));
      evt();
      chk("ret_ev2", obs(), trip(4, 5, 4));
      chk("ret_ev2_busy", 32'(busy), 32'd1);
      chk("ret_ev2_done", 32'(done), 32'd0);
      evt();
      chk("ret_ev3", obs(), trip(5, 4, 3));
      chk("ret_ev3_done", 32'(done), 32'd0);
      evt();
      chk("ret_ev4", obs(), trip(4, 3, 3));
      chk("ret_ev4_done", 32'(done), 32'd1);
      chk("ret_ev4_valid", 32'(nodes_valid), 32'd1);
      tick();
      chk("ret_post_done", 32'(done), 32'd0);
      chk("ret_post_busy", 32'(busy), 32'd0);
      chk("ret_post_hold", obs(), trip(4, 3, 3));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
